// File: rtl/video_fetch.sv
// video_fetch: fetches one scan line of 16-bit words from video RAM per line-end event and
// streams it to the line buffer. Define VIDEO_FETCH_OVERRUN_CNT_EN to build the overrun counter.
module video_fetch #(
    parameter int ADDR_W         = 18,
    parameter int WORDS_PER_LINE = 128,
    parameter int LINE_STRIDE    = 128,
    parameter int MAX_OUTST      = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [7:0]        i_line_idx,
    input  logic              i_line_end,
    input  logic              i_frame_end,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic              i_mem_rvalid,
    input  logic [15:0]       i_mem_rdata,
    output logic              o_vdata_valid,
    output logic              o_vdata_reset,
    output logic [15:0]       o_vdata,
    output logic              o_busy,
    output logic [7:0]        o_overrun_cnt
);
    localparam int ISS_W = $clog2(WORDS_PER_LINE + 1);
    localparam int OUT_W = 4;

    typedef enum logic [2:0] {ST_IDLE, ST_RST, ST_FETCH, ST_WAIT, ST_DRAIN} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] base_sh, line_addr, line_addr_d, addr, addr_d, start_addr;
    logic [ISS_W-1:0]  issued, issued_d, issued_nx;
    logic [OUT_W-1:0]  outst, outst_d;
    logic              req, req_d, to_rst, to_rst_d, ovr_inc, fire, ret;
    logic              vdata_valid, vdata_reset;
    logic [15:0]       vdata;

    assign fire       = req & i_mem_ack;
    assign ret        = i_mem_rvalid & (outst != '0);
    assign issued_nx  = issued + ISS_W'(fire);
    // Uses the registered base, so a coincident frame end only affects the following line.
    assign start_addr = base_sh + ADDR_W'(i_line_idx) * ADDR_W'(LINE_STRIDE);

    always_comb begin
        outst_d = outst;
        if (fire && !ret)
            outst_d = outst + OUT_W'(1);
        else if (!fire && ret)
            outst_d = outst - OUT_W'(1);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        req_d       = 1'b0;
        addr_d      = fire ? addr + ADDR_W'(1) : addr;
        issued_d    = issued_nx;
        line_addr_d = line_addr;
        to_rst_d    = to_rst;
        ovr_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_line_end && i_enable) begin
                    line_addr_d = start_addr;
                    state_d     = ST_RST;
                end
            end
            ST_RST: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (i_line_end) begin
                    line_addr_d = start_addr;
                end else begin
                    issued_d = '0;
                    addr_d   = line_addr;
                    req_d    = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH, ST_WAIT: begin
                if (!i_enable) begin
                    to_rst_d = 1'b0;
                    state_d  = ST_DRAIN;
                end else if (i_line_end) begin
                    line_addr_d = start_addr;
                    to_rst_d    = 1'b1;
                    ovr_inc     = 1'b1;
                    state_d     = ST_DRAIN;
                end else if (state == ST_WAIT) begin
                    if (outst == '0)
                        state_d = ST_IDLE;
                end else if (issued_nx == ISS_W'(WORDS_PER_LINE)) begin
                    state_d = ST_WAIT;
                end else begin
                    req_d = (outst_d < OUT_W'(MAX_OUTST));
                end
            end
            ST_DRAIN: begin
                if (i_line_end && i_enable) begin
                    line_addr_d = start_addr;
                    to_rst_d    = 1'b1;
                end
                if (outst == '0)
                    state_d = ((i_line_end && i_enable) || to_rst) ? ST_RST : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            req         <= 1'b0;
            addr        <= '0;
            issued      <= '0;
            outst       <= '0;
            line_addr   <= '0;
            to_rst      <= 1'b0;
            base_sh     <= '0;
            vdata_reset <= 1'b0;
            vdata_valid <= 1'b0;
            vdata       <= '0;
        end else begin
            state       <= state_d;
            req         <= req_d;
            addr        <= addr_d;
            issued      <= issued_d;
            outst       <= outst_d;
            line_addr   <= line_addr_d;
            to_rst      <= to_rst_d;
            vdata_reset <= (state_d == ST_RST);
            if (i_frame_end)
                base_sh <= i_base;
            // Data returning while draining belongs to an aborted line and is dropped.
            vdata_valid <= 1'b0;
            if (i_mem_rvalid && (state == ST_RST || state == ST_FETCH || state == ST_WAIT)) begin
                vdata_valid <= 1'b1;
                vdata       <= i_mem_rdata;
            end
        end
    end

`ifdef VIDEO_FETCH_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            ovr_cnt <= '0;
        else if (ovr_inc && ovr_cnt != 8'hFF)
            ovr_cnt <= ovr_cnt + 8'd1;
    end

    assign o_overrun_cnt = ovr_cnt;
`else
    logic unused_ovr_inc;
    assign unused_ovr_inc = ovr_inc;
    assign o_overrun_cnt  = '0;
`endif

    assign o_mem_req     = req;
    assign o_mem_addr    = addr;
    assign o_vdata_valid = vdata_valid;
    assign o_vdata_reset = vdata_reset;
    assign o_vdata       = vdata;
    assign o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch: a memory model with selectable ack pattern and read latency
// answers requests; every streamed word and issued address is compared against hand-derived values.
`timescale 1ns/1ps
module tb_video_fetch;
    localparam int ADDR_W = 18;
    localparam int WPL    = 128;
`ifdef VIDEO_FETCH_OVERRUN_CNT_EN
    localparam int EXP_OVR = 1;
`else
    localparam int EXP_OVR = 0;
`endif

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_enable = 1'b0;
    logic [ADDR_W-1:0] i_base = '0;
    logic [7:0]        i_line_idx = '0;
    logic              i_line_end = 1'b0;
    logic              i_frame_end = 1'b0;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack = 1'b0;
    logic              i_mem_rvalid = 1'b0;
    logic [15:0]       i_mem_rdata = '0;
    logic              o_vdata_valid;
    logic              o_vdata_reset;
    logic [15:0]       o_vdata;
    logic              o_busy;
    logic [7:0]        o_overrun_cnt;

    video_fetch #(.ADDR_W(ADDR_W), .WORDS_PER_LINE(WPL), .LINE_STRIDE(128), .MAX_OUTST(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_base(i_base),
        .i_line_idx(i_line_idx), .i_line_end(i_line_end), .i_frame_end(i_frame_end),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_vdata_valid(o_vdata_valid), .o_vdata_reset(o_vdata_reset), .o_vdata(o_vdata),
        .o_busy(o_busy), .o_overrun_cnt(o_overrun_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       due;
    } pend_t;

    pend_t             pend_q[$];
    logic [ADDR_W-1:0] fire_q[$];
    logic [15:0]       recv_q[$];
    int                mcyc = 0;
    int                inflight = 0;
    int                max_inflight = 0;
    int                lat = 2;
    bit                ack_toggle = 1'b0;
    int                n_cmp = 0;
    int                n_mis = 0;

    function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Memory model: drives ack/rvalid just after the rising edge, observes the port at the falling edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (i_reset) begin
                pend_q.delete();
                inflight     = 0;
                i_mem_ack    = 1'b0;
                i_mem_rvalid = 1'b0;
            end else begin
                i_mem_ack = ack_toggle ? (mcyc % 2 == 0) : 1'b1;
                if (pend_q.size() > 0 && pend_q[0].due == 32'(mcyc)) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = mem_word(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end else begin
                    i_mem_rvalid = 1'b0;
                end
            end
            @(negedge i_clk);
            if (!i_reset) begin
                if (o_mem_req && i_mem_ack) begin
                    pend_q.push_back(pend_t'{o_mem_addr, 32'(mcyc + lat)});
                    fire_q.push_back(o_mem_addr);
                    inflight++;
                end
                if (i_mem_rvalid)
                    inflight--;
                if (inflight > max_inflight)
                    max_inflight = inflight;
                if (o_vdata_valid)
                    recv_q.push_back(o_vdata);
            end
            mcyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 2000) begin
            tick();
            n++;
        end
        check({tag, " idle"}, 32'(n < 2000), 32'd1);
    endtask

    // Compares the words streamed and addresses issued since offsets r0/f0 with a full line at start.
    task automatic finish_line(input int r0, input int f0, input logic [ADDR_W-1:0] start,
                               input string tag);
        int bad = 0;
        logic [ADDR_W-1:0] a;
        wait_idle(tag);
        check({tag, " nwords"}, 32'(recv_q.size() - r0), 32'(WPL));
        check({tag, " nreqs"}, 32'(fire_q.size() - f0), 32'(WPL));
        for (int i = 0; i < WPL; i++) begin
            a = start + ADDR_W'(i);
            if (r0 + i < recv_q.size() && recv_q[r0 + i] !== mem_word(a))
                bad++;
            if (f0 + i < fire_q.size() && fire_q[f0 + i] !== a)
                bad++;
        end
        check({tag, " data"}, 32'(bad), 32'd0);
    endtask

    task automatic run_line(input logic [7:0] idx, input logic [ADDR_W-1:0] start,
                            input bit with_frame, input string tag, output int f0);
        int r0;
        r0          = recv_q.size();
        f0          = fire_q.size();
        i_line_idx  = idx;
        i_line_end  = 1'b1;
        i_frame_end = with_frame;
        tick();
        i_line_end  = 1'b0;
        i_frame_end = 1'b0;
        check({tag, " vreset"}, 32'(o_vdata_reset), 32'd1);
        tick();
        check({tag, " req"}, 32'(o_mem_req), 32'd1);
        check({tag, " addr0"}, 32'(o_mem_addr), 32'(start));
        finish_line(r0, f0, start, tag);
    endtask

    task automatic set_base(input logic [ADDR_W-1:0] b);
        i_base      = b;
        i_frame_end = 1'b1;
        tick();
        i_frame_end = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req"}, 32'(o_mem_req), 32'd0);
        check({tag, " addr"}, 32'(o_mem_addr), 32'd0);
        check({tag, " vvalid"}, 32'(o_vdata_valid), 32'd0);
        check({tag, " vreset"}, 32'(o_vdata_reset), 32'd0);
        check({tag, " vdata"}, 32'(o_vdata), 32'd0);
        check({tag, " busy"}, 32'(o_busy), 32'd0);
        check({tag, " ovr"}, 32'(o_overrun_cnt), 32'd0);
    endtask

    initial begin
        int f0, r0, r1, bad;

        // Reset state
        tick(2);
        check_all_zero("reset");
        i_reset  = 1'b0;
        i_enable = 1'b1;
        tick();

        // Line 3 from base 0x1000: 0x1180..0x11FF, ack always, latency 2
        set_base(18'h01000);
        run_line(8'd3, 18'h01180, 1'b0, "s1", f0);
        check("s1 last addr", 32'(fire_q[f0 + WPL - 1]), 32'h011FF);
        check("s1 busy", 32'(o_busy), 32'd0);

        // Toggling ack, latency 6
        ack_toggle = 1'b1;
        lat        = 6;
        tick(2);
        run_line(8'd1, 18'h01080, 1'b0, "s2", f0);

        // Overrun: line 5 requested while word 40 of line 4 is being issued
        ack_toggle = 1'b0;
        lat        = 2;
        tick(2);
        r0         = recv_q.size();
        i_line_idx = 8'd4;
        i_line_end = 1'b1;
        tick();
        i_line_end = 1'b0;
        check("s3 vreset", 32'(o_vdata_reset), 32'd1);
        tick();
        check("s3 addr0", 32'(o_mem_addr), 32'h01200);
        tick(40);
        i_line_idx = 8'd5;
        i_line_end = 1'b1;
        tick();
        i_line_end = 1'b0;
        check("s3 req drop", 32'(o_mem_req), 32'd0);
        check("s3 busy", 32'(o_busy), 32'd1);
        check("s3 ovr", 32'(o_overrun_cnt), 32'(EXP_OVR));
        tick(2);
        check("s3 drain no vreset", 32'(o_vdata_reset), 32'd0);
        tick();
        check("s3 vreset2", 32'(o_vdata_reset), 32'd1);
        check("s3 line4 words", 32'(recv_q.size() - r0), 32'd39);
        bad = 0;
        for (int i = 0; i < 39; i++)
            if (r0 + i < recv_q.size() && recv_q[r0 + i] !== mem_word(18'h01200 + ADDR_W'(i)))
                bad++;
        check("s3 line4 data", 32'(bad), 32'd0);
        r1 = recv_q.size();
        f0 = fire_q.size();
        tick();
        check("s3 req5", 32'(o_mem_req), 32'd1);
        check("s3 addr5", 32'(o_mem_addr), 32'h01280);
        finish_line(r1, f0, 18'h01280, "s3b");

        // Address wrap at 2^18, latency 6 so the outstanding limit is reached
        lat = 6;
        set_base(18'h3FFC0);
        run_line(8'd0, 18'h3FFC0, 1'b0, "s4", f0);
        check("s4 addr63", 32'(fire_q[f0 + 63]), 32'h3FFFF);
        check("s4 addr64", 32'(fire_q[f0 + 64]), 32'h00000);
        check("s4 addr127", 32'(fire_q[f0 + 127]), 32'h0003F);

        // Frame end coincident with line end: this line uses the old base
        lat = 2;
        set_base(18'h01000);
        i_base = 18'h02000;
        run_line(8'd0, 18'h01000, 1'b1, "s5a", f0);
        tick(2);
        run_line(8'd0, 18'h02000, 1'b0, "s5b", f0);

        // Async reset in the middle of a fetch
        tick(2);
        i_line_idx = 8'd3;
        i_line_end = 1'b1;
        tick();
        i_line_end = 1'b0;
        tick(10);
        #2;
        i_reset = 1'b1;
        #1;
        check_all_zero("s6 async");
        tick(2);
        i_reset = 1'b0;
        tick();
        set_base(18'h01000);
        run_line(8'd3, 18'h01180, 1'b0, "s6", f0);

        check("max inflight", 32'(max_inflight), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
